// File: rtl/gates_pkg.sv
// Shared definitions for the basic-gates library.
// Truth-table combination indices are formed as {operand A bit, operand B bit}.
package gates_pkg;

    localparam int C00 = 0;
    localparam int C01 = 1;
    localparam int C10 = 2;
    localparam int C11 = 3;
    localparam int NUM_COMBOS = 4;

    typedef logic [1:0] combo_t;

    function automatic combo_t combo_of(input logic a, input logic b);
        return {a, b};
    endfunction

endpackage

// File: rtl/nor_cov_mon.sv
// Sticky truth-table coverage monitor with one saturating counter per input combination.
// Updates one cycle after a qualified sample; never stalls, counters pin at all-ones.
module nor_cov_mon
    import gates_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             smp_vld,
    input  logic             a,
    input  logic             b,
    output logic [3:0]       seen,
    output logic [CNT_W-1:0] cnt_00,
    output logic [CNT_W-1:0] cnt_01,
    output logic [CNT_W-1:0] cnt_10,
    output logic [CNT_W-1:0] cnt_11,
    output logic             all_seen
);

    logic [NUM_COMBOS-1:0]            hit;
    logic [NUM_COMBOS-1:0][CNT_W-1:0] cnt_q;

    // An unknown operand bit matches no case item, so nothing is recorded.
    always_comb begin
        hit = '0;
        if (smp_vld) begin
            case (combo_of(a, b))
                2'b00:   hit[C00] = 1'b1;
                2'b01:   hit[C01] = 1'b1;
                2'b10:   hit[C10] = 1'b1;
                2'b11:   hit[C11] = 1'b1;
                default: hit      = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen  <= '0;
            cnt_q <= '0;
        end else begin
            seen <= seen | hit;
            for (int k = 0; k < NUM_COMBOS; k++) begin
                if (hit[k] && (cnt_q[k] != '1)) begin
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    assign cnt_00   = cnt_q[C00];
    assign cnt_01   = cnt_q[C01];
    assign cnt_10   = cnt_q[C10];
    assign cnt_11   = cnt_q[C11];
    assign all_seen = &seen;

endmodule

// File: rtl/nor_gate.sv
// WIDTH-bit NOR: combinational Out/red_nor, plus a 1-cycle registered copy with valid strobe.
// No backpressure: out_vld is a single-cycle pulse per valid input; coverage taps bit 0.
module nor_gate
    import gates_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             in_vld,
    output logic [WIDTH-1:0] Out,
    output logic [WIDTH-1:0] Out_q,
    output logic             out_vld,
    output logic             red_nor,
    output logic [3:0]       seen,
    output logic [CNT_W-1:0] cnt_00,
    output logic [CNT_W-1:0] cnt_01,
    output logic [CNT_W-1:0] cnt_10,
    output logic [CNT_W-1:0] cnt_11,
    output logic             all_seen
);

    logic [WIDTH-1:0] nor_dat;

    assign nor_dat = ~(I0 | I1);
    assign Out     = nor_dat;
    assign red_nor = ~|(I0 | I1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Out_q   <= '0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                Out_q <= nor_dat;
            end
        end
    end

    nor_cov_mon #(
        .CNT_W (CNT_W)
    ) u_cov (
        .clk      (clk),
        .rst_n    (rst_n),
        .smp_vld  (in_vld),
        .a        (I0[0]),
        .b        (I1[0]),
        .seen     (seen),
        .cnt_00   (cnt_00),
        .cnt_01   (cnt_01),
        .cnt_10   (cnt_10),
        .cnt_11   (cnt_11),
        .all_seen (all_seen)
    );

endmodule

// File: tb/tb_nor_gate.sv
// Bench for nor_gate: three instances (1-bit, 1-bit with 2-bit counters, 8-bit),
// table-driven combinational checks, directed register/coverage/reset sequences, random vs model.
module tb_nor_gate;

    logic clk;
    logic rst_n;

    // Instance 1: WIDTH=1, CNT_W=8
    logic       a1, b1, v1;
    logic       o1, oq1, ov1, red1, all1;
    logic [3:0] seen1;
    logic [7:0] c1_00, c1_01, c1_10, c1_11;

    // Instance 2: WIDTH=1, CNT_W=2
    logic       a2, b2, v2;
    logic       o2, oq2, ov2, red2, all2;
    logic [3:0] seen2;
    logic [1:0] c2_00, c2_01, c2_10, c2_11;

    // Instance 3: WIDTH=8, CNT_W=8
    logic [7:0] a8, b8;
    logic       v8;
    logic [7:0] o8, oq8;
    logic       ov8, red8, all8;
    logic [3:0] seen8;
    logic [7:0] c8_00, c8_01, c8_10, c8_11;

    int n_cmp;
    int n_err;

    nor_gate #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .I0(a1), .I1(b1), .in_vld(v1),
        .Out(o1), .Out_q(oq1), .out_vld(ov1), .red_nor(red1), .seen(seen1),
        .cnt_00(c1_00), .cnt_01(c1_01), .cnt_10(c1_10), .cnt_11(c1_11), .all_seen(all1)
    );

    nor_gate #(.WIDTH(1), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .I0(a2), .I1(b2), .in_vld(v2),
        .Out(o2), .Out_q(oq2), .out_vld(ov2), .red_nor(red2), .seen(seen2),
        .cnt_00(c2_00), .cnt_01(c2_01), .cnt_10(c2_10), .cnt_11(c2_11), .all_seen(all2)
    );

    nor_gate #(.WIDTH(8), .CNT_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .I0(a8), .I1(b8), .in_vld(v8),
        .Out(o8), .Out_q(oq8), .out_vld(ov8), .red_nor(red8), .seen(seen8),
        .cnt_00(c8_00), .cnt_01(c8_01), .cnt_10(c8_10), .cnt_11(c8_11), .all_seen(all8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] i0;
        logic [7:0] i1;
        logic [7:0] exp_out;
        logic       exp_red;
    } vec_t;

    vec_t tt1 [4];
    vec_t tt8 [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the random phase
    int         n_seen [4];
    logic [7:0] m_q8;
    logic       m_q2;
    logic       m_vld;
    logic [7:0] ra, rb;
    logic       rv;
    logic [1:0] kk;
    int         exp_sat2;

    function automatic int sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
        a2 = 1'b0; b2 = 1'b0; v2 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; v8 = 1'b0;

        tt1[0] = '{8'h00, 8'h00, 8'h01, 1'b1};
        tt1[1] = '{8'h00, 8'h01, 8'h00, 1'b0};
        tt1[2] = '{8'h01, 8'h00, 8'h00, 1'b0};
        tt1[3] = '{8'h01, 8'h01, 8'h00, 1'b0};

        tt8[0] = '{8'hF0, 8'h0C, 8'h03, 1'b0};
        tt8[1] = '{8'h00, 8'h00, 8'hFF, 1'b1};
        tt8[2] = '{8'hFF, 8'h00, 8'h00, 1'b0};
        tt8[3] = '{8'hAA, 8'h55, 8'h00, 1'b0};
        tt8[4] = '{8'h01, 8'h00, 8'hFE, 1'b0};
        tt8[5] = '{8'h00, 8'h80, 8'h7F, 1'b0};

        // Reset state before any clock edge
        #2;
        chk("rst_out_q", 32'(oq1), 32'h0);
        chk("rst_out_vld", 32'(ov1), 32'h0);
        chk("rst_seen", 32'(seen1), 32'h0);
        chk("rst_cnt", {c1_00, c1_01, c1_10, c1_11}, 32'h0);
        chk("rst_all_seen", 32'(all1), 32'h0);

        // Combinational truth table, 1-bit
        for (int i = 0; i < 4; i++) begin
            a1 = tt1[i].i0[0];
            b1 = tt1[i].i1[0];
            #1;
            chk($sformatf("tt1_out[%0d]", i), 32'(o1), 32'(tt1[i].exp_out[0]));
            chk($sformatf("tt1_red[%0d]", i), 32'(red1), 32'(tt1[i].exp_red));
        end

        // Combinational, 8-bit
        for (int i = 0; i < 6; i++) begin
            a8 = tt8[i].i0;
            b8 = tt8[i].i1;
            #1;
            chk($sformatf("tt8_out[%0d]", i), 32'(o8), 32'(tt8[i].exp_out));
            chk($sformatf("tt8_red[%0d]", i), 32'(red8), 32'(tt8[i].exp_red));
        end

        // Registers stay cleared across an edge while reset is held
        a1 = 1'b0; b1 = 1'b0; v1 = 1'b1;
        edge_settle();
        chk("held_rst_out_q", 32'(oq1), 32'h0);
        chk("held_rst_seen", 32'(seen1), 32'h0);
        v1 = 1'b0;
        rst_n = 1'b1;

        // Registered path
        a1 = 1'b0; b1 = 1'b0; v1 = 1'b1;
        edge_settle();
        chk("reg_out_q", 32'(oq1), 32'h1);
        chk("reg_out_vld", 32'(ov1), 32'h1);
        v1 = 1'b0; a1 = 1'b1;
        edge_settle();
        chk("reg_hold_out_q", 32'(oq1), 32'h1);
        chk("reg_vld_drop", 32'(ov1), 32'h0);

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;

        // Coverage over all four combinations
        for (int k = 0; k < 4; k++) begin
            kk = 2'(k);
            a1 = kk[1]; b1 = kk[0]; v1 = 1'b1;
            edge_settle();
            chk($sformatf("cov_seen[%0d]", k), 32'(seen1), (32'h1 << (k + 1)) - 32'h1);
            chk($sformatf("cov_all[%0d]", k), 32'(all1), (k == 3) ? 32'h1 : 32'h0);
        end
        chk("cov_cnt_00", 32'(c1_00), 32'h1);
        chk("cov_cnt_01", 32'(c1_01), 32'h1);
        chk("cov_cnt_10", 32'(c1_10), 32'h1);
        chk("cov_cnt_11", 32'(c1_11), 32'h1);
        v1 = 1'b0;

        // Saturation with 2-bit counters
        for (int i = 1; i <= 5; i++) begin
            a2 = 1'b1; b2 = 1'b1; v2 = 1'b1;
            edge_settle();
            chk($sformatf("sat_cnt_11[%0d]", i), 32'(c2_11), 32'(sat(i, 3)));
        end
        v2 = 1'b0;
        chk("sat_others", {c2_00, c2_01, c2_10}, 32'h0);

        // Async reset between edges with an output pulse in flight
        a1 = 1'b0; b1 = 1'b0; v1 = 1'b1;
        edge_settle();
        chk("pre_rst_out_q", 32'(oq1), 32'h1);
        chk("pre_rst_out_vld", 32'(ov1), 32'h1);
        chk("pre_rst_cnt_00", 32'(c1_00), 32'h2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_q", 32'(oq1), 32'h0);
        chk("arst_out_vld", 32'(ov1), 32'h0);
        chk("arst_seen", 32'(seen1), 32'h0);
        chk("arst_all_seen", 32'(all1), 32'h0);
        chk("arst_cnt", {c1_00, c1_01, c1_10, c1_11}, 32'h0);
        chk("arst_cnt2_11", 32'(c2_11), 32'h0);
        a1 = 1'b1;
        #1;
        chk("arst_out_tracks0", 32'(o1), 32'h0);
        a1 = 1'b0;
        #1;
        chk("arst_out_tracks1", 32'(o1), 32'h1);
        edge_settle();
        chk("arst_held_out_vld", 32'(ov1), 32'h0);
        v1 = 1'b0;
        rst_n = 1'b1;

        // Random traffic on the 8-bit and saturating instances against a counting model
        for (int k = 0; k < 4; k++) n_seen[k] = 0;
        m_q8  = 8'h00;
        m_q2  = 1'b0;
        m_vld = 1'b0;
        for (int c = 0; c < 300; c++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rv = ($urandom_range(0, 3) != 0);
            a8 = ra; b8 = rb; v8 = rv;
            a2 = ra[0]; b2 = rb[0]; v2 = rv;
            #1;
            chk("rnd_out", 32'(o8), 32'(8'hFF - (ra | rb)));
            chk("rnd_red", 32'(red8), ((ra | rb) == 8'h00) ? 32'h1 : 32'h0);
            @(posedge clk);
            #1;
            m_vld = rv;
            if (rv) begin
                m_q8 = 8'hFF - (ra | rb);
                m_q2 = ~(ra[0] | rb[0]);
                n_seen[ra[0] * 2 + rb[0]]++;
            end
            chk("rnd_out_q", 32'(oq8), 32'(m_q8));
            chk("rnd_out_vld", 32'(ov8), 32'(m_vld));
            chk("rnd_out_q_w1", 32'(oq2), 32'(m_q2));
            chk("rnd_cnt8", {c8_00, c8_01, c8_10, c8_11},
                {8'(sat(n_seen[0], 255)), 8'(sat(n_seen[1], 255)),
                 8'(sat(n_seen[2], 255)), 8'(sat(n_seen[3], 255))});
            exp_sat2 = sat(n_seen[0], 3) * 64 + sat(n_seen[1], 3) * 16
                     + sat(n_seen[2], 3) * 4 + sat(n_seen[3], 3);
            chk("rnd_cnt2", 32'({c2_00, c2_01, c2_10, c2_11}), 32'(exp_sat2));
            chk("rnd_seen", 32'(seen8),
                32'({n_seen[3] > 0, n_seen[2] > 0, n_seen[1] > 0, n_seen[0] > 0}));
            chk("rnd_all_seen", 32'(all8),
                (n_seen[0] > 0 && n_seen[1] > 0 && n_seen[2] > 0 && n_seen[3] > 0) ? 32'h1 : 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
